imem_fetch_ctrl: RTL and testbench

- Sequences the byte-addressed, registered-output instruction memory: owns the fetch PC and drives the memory address.
- Delivers one instruction per cycle to decode over a valid/ready handshake.
- Handles redirects (branch/jump), halt requests and fetch faults (misaligned or out-of-range PC).
- Sits between the instruction memory and the decode stage of the single-cycle RISC-V core.

---
 rtl/rv_fetch_pkg.sv | 18 +
 rtl/imem_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_HALT,
        FETCH_FAULT
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Word aligned and the whole instruction fits inside the memory.
    function automatic logic addr_legal(input logic [31:0] pc, input logic [31:0] mem_size);
        return (pc[1:0] == 2'b00) && (pc <= mem_size - INSTR_BYTES);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a registered-output instruction memory
// and hands one beat per cycle to decode over valid/ready.
module imem_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] retire_count
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE);

    fetch_state_e state;
    logic         inflight_valid;
    logic [31:0]  inflight_pc;
    logic         inflight_fault;
    logic         resume_exact;

    logic         accept;
    logic         stall;
    logic         can_issue;
    logic [31:0]  tgt;

    assign if_valid = inflight_valid && !redirect_valid;
    assign if_pc    = inflight_pc;
    assign if_fault = inflight_fault;
    assign if_instr = inflight_fault ? 32'h0 : imem_instr;

    assign accept = if_valid && if_ready;
    assign stall  = if_valid && !if_ready;

    // A stalled beat re-addresses its own PC so the memory output stays put.
    always_comb begin
        tgt = inflight_pc + INSTR_BYTES;
        if (redirect_valid)
            tgt = redirect_pc;
        else if (stall)
            tgt = inflight_pc;
        else if (state == FETCH_BOOT)
            tgt = RESET_PC;
        else if (resume_exact)
            tgt = inflight_pc;
    end

    assign imem_addr = tgt;

    // A faulting beat being accepted must not pull in the next PC.
    assign can_issue = (redirect_valid ||
                        ((state == FETCH_BOOT || state == FETCH_RUN) &&
                         !(if_valid && inflight_fault)))
                     && !halt_req
                     && (!if_valid || if_ready || redirect_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH_BOOT;
            inflight_valid <= 1'b0;
            inflight_pc    <= RESET_PC;
            inflight_fault <= 1'b0;
            resume_exact   <= 1'b1;
            retire_count   <= 32'h0;
        end else begin
            if (accept && !inflight_fault)
                retire_count <= retire_count + 32'd1;

            if (can_issue) begin
                inflight_valid <= 1'b1;
                inflight_pc    <= tgt;
                inflight_fault <= !addr_legal(tgt, MEM_BYTES);
                resume_exact   <= 1'b0;
                state          <= FETCH_RUN;
            end else if (redirect_valid) begin
                // Redirect under halt: park the target and resume exactly there.
                inflight_valid <= 1'b0;
                inflight_pc    <= redirect_pc;
                inflight_fault <= 1'b0;
                resume_exact   <= 1'b1;
                state          <= FETCH_HALT;
            end else if (accept && inflight_fault) begin
                inflight_valid <= 1'b0;
                state          <= FETCH_FAULT;
            end else if (!stall) begin
                inflight_valid <= 1'b0;
                case (state)
                    FETCH_BOOT, FETCH_RUN: if (halt_req)  state <= FETCH_HALT;
                    FETCH_HALT:            if (!halt_req) state <= FETCH_RUN;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MEM_SIZE = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] retire_count;

    logic [31:0] mem [0:63];

    int n_vec = 0;
    int n_err = 0;

    imem_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_fault(if_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Registered-output memory; out-of-range reads return junk that must be masked.
    always @(posedge clk)
        imem_instr <= (imem_addr < 32'(MEM_SIZE)) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    function automatic logic legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc + 64'd4 <= 64'(MEM_SIZE));
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[7:2]];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load_program;
        for (int i = 0; i < 64; i++) mem[i] = {8'hA5, 16'(i), 8'h13};
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
    endtask

    task automatic do_reset;
        reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt_req = 1'b0;
        step; step;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int cnt;
        cnt = 0;
        while (!if_valid && cnt < 8) begin step; cnt++; end
        n_vec++;
        if (if_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_timeout: if_valid=%b want 1 within 8 cycles", name, if_valid);
        end
    endtask

    task automatic test_reset;
        do_reset;
        settle;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_vec++; if (if_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", if_fault); end
        n_vec++; if (if_pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", if_pc, RESET_PC); end
        n_vec++; if (retire_count !== 32'h0) begin n_err++; $display("FAIL reset_retire: got %0d want 0", retire_count); end
        n_vec++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        step; step; step;
        reset = 1'b1;
        step;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", if_valid); end
        n_vec++; if (retire_count !== 32'h0) begin n_err++; $display("FAIL midreset_retire: got %0d want 0", retire_count); end
        reset = 1'b0;
    endtask

    task automatic test_stream;
        logic [31:0] pcs [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        do_reset;
        step;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (if_valid !== 1'b1 || if_pc !== pcs[i]) begin
                n_err++; $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", i, if_valid, if_pc, pcs[i]);
            end
            n_vec++; if (if_instr !== word_at(pcs[i])) begin
                n_err++; $display("FAIL stream_instr%0d: got %h want %h", i, if_instr, word_at(pcs[i]));
            end
            step;
        end
        if_ready = 1'b0;
        settle;
        n_vec++; if (retire_count !== 32'd3) begin n_err++; $display("FAIL stream_retire: got %0d want 3", retire_count); end
    endtask

    task automatic test_stall;
        do_reset;
        step; step;
        if_ready = 1'b0;
        settle;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0010_0093) begin
                n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h want v=1 pc=4 instr=00100093", k, if_valid, if_pc, if_instr);
            end
            n_vec++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL stall_addr%0d: got %h want 4", k, imem_addr); end
            if (k < 2) step;
        end
        if_ready = 1'b1;
        step;
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
            n_err++; $display("FAIL stall_resume: got v=%b pc=%h want v=1 pc=8", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect;
        do_reset;
        step; step; step;
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        settle;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_kill: got %b want 0", if_valid); end
        n_vec++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
        step;
        redirect_valid = 1'b0; if_ready = 1'b1;
        settle;
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== word_at(32'h40)) begin
            n_err++; $display("FAIL redir_beat: got v=%b pc=%h instr=%h want v=1 pc=40 instr=%h", if_valid, if_pc, if_instr, word_at(32'h40));
        end
        n_vec++; if (retire_count !== 32'd2) begin n_err++; $display("FAIL redir_retire: got %0d want 2", retire_count); end
    endtask

    task automatic test_fault;
        do_reset;
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step;
        redirect_valid = 1'b0;
        settle;
        n_vec++; if (if_valid !== 1'b1 || if_fault !== 1'b1 || if_instr !== 32'h0 || if_pc !== 32'h42) begin
            n_err++; $display("FAIL fault_beat: got v=%b f=%b instr=%h pc=%h want 1 1 0 42", if_valid, if_fault, if_instr, if_pc);
        end
        step;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fault_dead%0d: got %b want 0", k, if_valid); end
            step;
        end
        n_vec++; if (retire_count !== 32'd0) begin n_err++; $display("FAIL fault_retire: got %0d want 0", retire_count); end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step;
        redirect_valid = 1'b0;
        settle;
        n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_fault !== 1'b0) begin
            n_err++; $display("FAIL fault_recover: got v=%b pc=%h f=%b want 1 10 0", if_valid, if_pc, if_fault);
        end
    endtask

    task automatic test_boundary;
        logic [31:0] pcs [5];
        pcs = '{32'hF0, 32'hF4, 32'hF8, 32'hFC, 32'h100};
        do_reset;
        step;
        redirect_valid = 1'b1; redirect_pc = 32'hF0;
        step;
        redirect_valid = 1'b0;
        settle;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (if_valid !== 1'b1 || if_pc !== pcs[i] || if_fault !== (i == 4)) begin
                n_err++; $display("FAIL bound_%h: got v=%b pc=%h f=%b want v=1 f=%b", pcs[i], if_valid, if_pc, if_fault, (i == 4));
            end
            step;
        end
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL bound_after: got %b want 0", if_valid); end
    endtask

    task automatic test_halt;
        do_reset;
        step;
        redirect_valid = 1'b1; redirect_pc = 32'h18;
        step;
        redirect_valid = 1'b0;
        step; step;
        settle;
        n_vec++; if (if_pc !== 32'h20 || if_valid !== 1'b1) begin n_err++; $display("FAIL halt_pre: got v=%b pc=%h want 1 20", if_valid, if_pc); end
        halt_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step;
            n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL halt_quiet%0d: got %b want 0", k, if_valid); end
        end
        halt_req = 1'b0;
        settle;
        wait_valid("halt_resume");
        n_vec++; if (if_pc !== 32'h24) begin n_err++; $display("FAIL halt_resume_pc: got %h want 24", if_pc); end
        halt_req = 1'b1;
        step; step;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step;
        redirect_valid = 1'b0;
        settle;
        n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL halt_redir_quiet: got %b want 0", if_valid); end
        step;
        halt_req = 1'b0;
        settle;
        wait_valid("halt_redir");
        n_vec++; if (if_pc !== 32'h80) begin n_err++; $display("FAIL halt_redir_pc: got %h want 80", if_pc); end
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return 32'($urandom_range(0, 63)) << 2;
        if (r < 14) return ($urandom_range(0, 1) == 0) ? 32'hF8 : 32'hFC;
        if (r < 17) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (r < 19) return 32'h100 + (32'($urandom_range(0, 255)) << 2);
        return 32'hFFFF_FFFC;
    endfunction

    // Model: the stream of beats is exp_pc, exp_pc+4, ... until a redirect or
    // an accepted faulting beat; nothing may appear while dead or halted.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] exp_retire;
        logic        dead, prev_stall, prev_halt_block, prev_redir_go, acc;
        int          halt_left;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        do_reset;
        exp_pc = RESET_PC; exp_retire = 0; dead = 1'b0;
        prev_stall = 1'b0; prev_halt_block = 1'b0; prev_redir_go = 1'b0; halt_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if_ready = ($urandom_range(0, 9) < 7);
            if (halt_left > 0) begin halt_req = 1'b1; halt_left--; end
            else if ($urandom_range(0, 19) == 0) begin halt_req = 1'b1; halt_left = $urandom_range(0, 5); end
            else halt_req = 1'b0;
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = pick_target();
            settle;
            if (redirect_valid) begin
                n_vec++; if (if_valid !== 1'b0 || imem_addr !== redirect_pc) begin
                    n_err++; $display("FAIL rnd_redir c%0d: got v=%b addr=%h want v=0 addr=%h", cyc, if_valid, imem_addr, redirect_pc);
                end
            end else if (if_valid) begin
                n_vec++; if (dead || if_pc !== exp_pc || if_fault !== !legal(exp_pc) ||
                             if_instr !== (legal(exp_pc) ? word_at(exp_pc) : 32'h0)) begin
                    n_err++; $display("FAIL rnd_beat c%0d: got pc=%h f=%b instr=%h dead=%b want pc=%h f=%b", cyc, if_pc, if_fault, if_instr, dead, exp_pc, !legal(exp_pc));
                end
                if (!if_ready) begin
                    n_vec++; if (imem_addr !== if_pc) begin n_err++; $display("FAIL rnd_stall_addr c%0d: got %h want %h", cyc, imem_addr, if_pc); end
                end
            end else begin
                if (prev_stall) begin n_vec++; n_err++; $display("FAIL rnd_stall_drop c%0d: got v=0 want 1", cyc); end
                if (prev_redir_go) begin n_vec++; n_err++; $display("FAIL rnd_redir_lat c%0d: got v=0 want 1", cyc); end
            end
            if (prev_halt_block) begin
                n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rnd_halt c%0d: got v=%b want 0", cyc, if_valid); end
            end
            n_vec++; if (retire_count !== exp_retire) begin
                n_err++; $display("FAIL rnd_retire c%0d: got %0d want %0d", cyc, retire_count, exp_retire);
            end
            acc = if_valid && if_ready;
            if (redirect_valid) begin exp_pc = redirect_pc; dead = 1'b0; end
            else if (acc) begin
                if (legal(exp_pc)) begin exp_retire++; exp_pc += 32'd4; end
                else dead = 1'b1;
            end
            prev_stall      = if_valid && !if_ready && !redirect_valid;
            prev_halt_block = halt_req && (!if_valid || if_ready);
            prev_redir_go   = redirect_valid && !halt_req;
            step;
        end
    endtask

    initial begin
        load_program;
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_fault;
        test_boundary;
        test_halt;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
